// File: rtl/store_buffer_mem_stage_pkg.sv
// Shared widths and entry layout for the MEM-stage store buffer.
// Optional youngest-match load forwarding is enabled by defining STORE_FWD_EN.
package store_buffer_mem_stage_pkg;

  localparam int WORD_LEN         = 32;
  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_TAG_LEN       = WORD_LEN - 2;

  typedef struct packed {
    logic [SB_TAG_LEN-1:0] tag;
    logic [WORD_LEN-1:0]   data;
  } sb_entry_t;

  function automatic logic [SB_TAG_LEN-1:0] word_tag(input logic [WORD_LEN-1:0] addr);
    return addr[WORD_LEN-1:2];
  endfunction

endpackage

// File: rtl/store_buffer_mem_stage_sb_fifo.sv
// Circular store buffer with per-entry valid bits and an address search port.
// With STORE_FWD_EN the search also returns the data of the youngest match.
module sb_fifo
  import store_buffer_mem_stage_pkg::*;
#(
  parameter  int DEPTH   = SB_DEPTH_DEFAULT,
  localparam int PTR_LEN = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [SB_TAG_LEN-1:0] push_tag,
  input  logic [WORD_LEN-1:0]   push_data,
  input  logic                  pop,
  output logic [SB_TAG_LEN-1:0] head_tag,
  output logic [WORD_LEN-1:0]   head_data,
  output logic [PTR_LEN:0]      count,
  input  logic [SB_TAG_LEN-1:0] search_tag,
`ifdef STORE_FWD_EN
  output logic [WORD_LEN-1:0]   hit_data,
`endif
  output logic                  hit
);

  sb_entry_t          entry_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_LEN-1:0] head_q;
  logic [PTR_LEN-1:0] tail_q;
  logic [PTR_LEN:0]   count_q;
  logic [PTR_LEN-1:0] search_idx;

  // NOTE: only control state is reset; payloads are qualified by valid_q, so resetting the array would add flops for nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_LEN'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_LEN'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_LEN+1)'(1);
        2'b01:   count_q <= count_q - (PTR_LEN+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) entry_q[tail_q] <= '{tag: push_tag, data: push_data};
  end

  assign head_tag  = entry_q[head_q].tag;
  assign head_data = entry_q[head_q].data;
  assign count     = count_q;

  // Walk oldest to youngest so the last match seen is the youngest one.
  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    hit        = 1'b0;
    search_idx = head_q;
`ifdef STORE_FWD_EN
    hit_data   = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      search_idx = head_q + PTR_LEN'(i);
      if (valid_q[search_idx] && entry_q[search_idx].tag == search_tag) begin
        hit      = 1'b1;
`ifdef STORE_FWD_EN
        hit_data = entry_q[search_idx].data;
`endif
      end
    end
  end

endmodule

// File: rtl/store_buffer_mem_stage.sv
// MEM-stage front end: posts stores into sb_fifo, drains them on idle cycles, services loads.
// STORE_FWD_EN selects buffer forwarding; otherwise a matching load stalls until drained.
module store_buffer_mem_stage
  import store_buffer_mem_stage_pkg::*;
#(
  parameter  int SB_DEPTH   = SB_DEPTH_DEFAULT,
  localparam int SB_PTR_LEN = $clog2(SB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memReadIn,
  input  logic                  memWriteIn,
  input  logic [WORD_LEN-1:0]   addressIn,
  input  logic [WORD_LEN-1:0]   storeDataIn,
  output logic [WORD_LEN-1:0]   loadDataOut,
  output logic                  stall,
  output logic                  memWriteEn,
  output logic [WORD_LEN-1:0]   memAddress,
  output logic [WORD_LEN-1:0]   memDataIn,
  input  logic [WORD_LEN-1:0]   memDataOut,
  output logic [SB_PTR_LEN:0]   sbCount
);

  localparam logic [SB_PTR_LEN:0] FULL_COUNT = (SB_PTR_LEN+1)'(SB_DEPTH);

  logic                  is_load;
  logic                  full;
  logic                  empty;
  logic                  drain;
  logic                  accept;
  logic                  hit;
  logic [SB_TAG_LEN-1:0] head_tag;
  logic [WORD_LEN-1:0]   head_data;
`ifdef STORE_FWD_EN
  logic [WORD_LEN-1:0]   hit_data;
`endif

  sb_fifo #(.DEPTH(SB_DEPTH)) u_sb_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_tag   (word_tag(addressIn)),
    .push_data  (storeDataIn),
    .pop        (drain),
    .head_tag   (head_tag),
    .head_data  (head_data),
    .count      (sbCount),
    .search_tag (word_tag(addressIn)),
`ifdef STORE_FWD_EN
    .hit_data   (hit_data),
`endif
    .hit        (hit)
  );

  // A simultaneous read and write is illegal; the store wins.
  assign is_load = memReadIn & ~memWriteIn;
  assign full    = (sbCount == FULL_COUNT);
  assign empty   = (sbCount == '0);

`ifdef STORE_FWD_EN
  assign stall = memWriteIn & full;
`else
  assign stall = (memWriteIn & full) | (is_load & hit);
`endif

  // A stall cycle is also a drain cycle, which bounds every stall.
  assign drain  = ~empty & ((~memReadIn & ~memWriteIn) | stall);
  assign accept = memWriteIn & ~stall;

  // NOTE: combinational outputs use blocking assignments; only clocked state uses <=.
  always_comb begin
    memWriteEn  = drain;
    memAddress  = '0;
    memDataIn   = '0;
    loadDataOut = '0;
    if (drain) begin
      memAddress = {head_tag, 2'b00};
      memDataIn  = head_data;
    end else if (is_load) begin
      memAddress = addressIn;
    end
    if (is_load) begin
`ifdef STORE_FWD_EN
      loadDataOut = hit ? hit_data : memDataOut;
`else
      loadDataOut = memDataOut;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(memReadIn && memWriteIn));
  end

endmodule
